// File: rtl/chunked_add_sub_if.sv
// Operand/result bundle for the chunked adder/subtractor: start/busy/done
// handshake plus operands and registered results.
interface chunked_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock from LSB to
// MSB with a registered inter-chunk carry, behind a start/busy/done handshake.
module chunked_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  chunked_add_sub_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = CHUNK + 1;
  localparam int MSB   = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             c_out_r;
  logic             overflow_r;
  logic [IDX_W-1:0] idx;
  logic [31:0]      base;
  logic [CHUNK:0]   chunk_res;
  logic             accept;
  logic             last;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + CW'(ci);
  endfunction

  // Operands of equal sign producing a result of the other sign.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  assign accept = bus.start && (state != BUSY);
  assign last   = (state == BUSY) && (idx == LAST_IDX);
  assign base   = 32'(idx) * CHUNK;

  always_comb begin
    chunk_res = chunk_add(a_r[base +: CHUNK], b_r[base +: CHUNK], carry_r);
    result    = acc;
    result[base +: CHUNK] = chunk_res[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? BUSY : IDLE;
      BUSY:    state_nxt = last ? DONE : BUSY;
      DONE:    state_nxt = bus.start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == BUSY);
    bus.done = (state == DONE);
  end

  // Operand capture; subtraction is folded in as A + ~B + 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= bus.a;
      b_r <= bus.sub ? ~bus.b : bus.b;
    end
  end

  // Chunk stage: one CHUNK-wide slice per cycle, result published on the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      carry_r    <= 1'b0;
      idx        <= '0;
      sum_r      <= '0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept) begin
      carry_r <= bus.sub ? 1'b1 : bus.c_in;
      idx     <= '0;
    end else if (state == BUSY) begin
      acc     <= result;
      carry_r <= chunk_res[CHUNK];
      idx     <= idx + IDX_W'(1);
      if (last) begin
        sum_r      <= result;
        c_out_r    <= chunk_res[CHUNK];
        overflow_r <= signed_ovf(a_r[MSB], b_r[MSB], result[MSB]);
      end
    end
  end

  assign bus.sum      = sum_r;
  assign bus.c_out    = c_out_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed vector table and multi-cycle sequences for chunked_add_sub, plus a
// random sweep across several WIDTH/CHUNK configurations.
module tb_chunked_add_sub;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  chunked_add_sub_if #(.WIDTH(16)) bus16 ();
  chunked_add_sub_if #(.WIDTH(32)) bus32 ();
  chunked_add_sub_if #(.WIDTH(8))  bus8  ();
  chunked_add_sub_if #(.WIDTH(12)) bus12 ();

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .reset(reset), .bus(bus16));
  chunked_add_sub #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .reset(reset), .bus(bus32));
  chunked_add_sub #(.WIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .reset(reset), .bus(bus8));
  chunked_add_sub #(.WIDTH(12), .CHUNK(3)) u12 (.clk(clk), .reset(reset), .bus(bus12));

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        c_in;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(string n, logic [15:0] a, logic [15:0] b, logic s,
                              logic ci, logic [15:0] r, logic co, logic ov);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.sub = s; v.c_in = ci;
    v.sum = r; v.c_out = co; v.ovf = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sum/carry and signed overflow from integer arithmetic.
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit s, input bit ci, output longint unsigned r,
                                output bit co, output bit ov);
    longint unsigned m;
    longint sa, sb, sr, lim;
    m   = (64'd1 << w) - 64'd1;
    lim = longint'(64'd1 << (w - 1));
    sa  = longint'(a);
    sb  = longint'(b);
    if (a[w-1]) sa -= longint'(64'd1 << w);
    if (b[w-1]) sb -= longint'(64'd1 << w);
    if (!s) begin
      r  = a + b + 64'(ci);
      co = r[w];
      sr = sa + sb + longint'(ci);
    end else begin
      r  = a - b;
      co = (a >= b);
      sr = sa - sb;
    end
    r  = r & m;
    ov = (sr >= lim) || (sr < -lim);
  endfunction

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci,
                       output logic [15:0] sum, output logic co, output logic ov,
                       output int lat, output int busy_cnt, output bit held);
    logic [15:0] prev;
    prev = bus16.sum;
    bus16.a = a; bus16.b = b; bus16.sub = s; bus16.c_in = ci; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.a = ~a; bus16.b = 16'h5A5A; bus16.sub = ~s; bus16.c_in = ~ci;
    sum = 'x; co = 1'bx; ov = 1'bx;
    lat = -1; busy_cnt = 0; held = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (bus16.busy) begin
        busy_cnt++;
        if (bus16.sum !== prev) held = 1'b0;
      end
      if (bus16.done) begin
        lat = k; sum = bus16.sum; co = bus16.c_out; ov = bus16.overflow;
        break;
      end
    end
  endtask

  task automatic sweep_once(input logic [31:0] a, input logic [31:0] b, input bit s, input bit ci);
    int                Ws[4] = '{16, 32, 8, 12};
    int                Ns[4] = '{4, 4, 1, 4};
    bit                got[4];
    int                lat[4];
    longint unsigned   rs[4];
    bit                co[4], ov[4];
    longint unsigned   er, am, bm;
    bit                eco, eov;
    bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.sub = s; bus16.c_in = ci; bus16.start = 1'b1;
    bus32.a = a;       bus32.b = b;       bus32.sub = s; bus32.c_in = ci; bus32.start = 1'b1;
    bus8.a  = a[7:0];  bus8.b  = b[7:0];  bus8.sub  = s; bus8.c_in  = ci; bus8.start  = 1'b1;
    bus12.a = a[11:0]; bus12.b = b[11:0]; bus12.sub = s; bus12.c_in = ci; bus12.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0; bus32.start = 1'b0; bus8.start = 1'b0; bus12.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got[i] = 1'b0; lat[i] = -1; rs[i] = '0; co[i] = 1'b0; ov[i] = 1'b0;
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus16.done && !got[0]) begin
        got[0] = 1'b1; lat[0] = k; rs[0] = 64'(bus16.sum); co[0] = bus16.c_out; ov[0] = bus16.overflow;
      end
      if (bus32.done && !got[1]) begin
        got[1] = 1'b1; lat[1] = k; rs[1] = 64'(bus32.sum); co[1] = bus32.c_out; ov[1] = bus32.overflow;
      end
      if (bus8.done && !got[2]) begin
        got[2] = 1'b1; lat[2] = k; rs[2] = 64'(bus8.sum); co[2] = bus8.c_out; ov[2] = bus8.overflow;
      end
      if (bus12.done && !got[3]) begin
        got[3] = 1'b1; lat[3] = k; rs[3] = 64'(bus12.sum); co[3] = bus12.c_out; ov[3] = bus12.overflow;
      end
    end
    for (int i = 0; i < 4; i++) begin
      am = 64'(a) & ((64'd1 << Ws[i]) - 64'd1);
      bm = 64'(b) & ((64'd1 << Ws[i]) - 64'd1);
      model(Ws[i], am, bm, s, ci, er, eco, eov);
      check($sformatf("sweep w%0d latency a=%0h b=%0h sub=%0d", Ws[i], am, bm, s), 64'(lat[i]), 64'(Ns[i]));
      check($sformatf("sweep w%0d sum a=%0h b=%0h sub=%0d cin=%0d", Ws[i], am, bm, s, ci), rs[i], er);
      check($sformatf("sweep w%0d c_out a=%0h b=%0h sub=%0d", Ws[i], am, bm, s), 64'(co[i]), 64'(eco));
      check($sformatf("sweep w%0d overflow a=%0h b=%0h sub=%0d", Ws[i], am, bm, s), 64'(ov[i]), 64'(eov));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        co, ov;
    int          lat, bc, dcnt, d1, d2;
    bit          held;
    logic [15:0] s1, s2;
    logic        co2;

    vecs[0] = mk("carry_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[1] = mk("signed_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[2] = mk("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    vecs[3] = mk("plain_add",    16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    vecs[4] = mk("cin_ripple",   16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    vecs[5] = mk("sub_ovf",      16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    vecs[6] = mk("sub_equal",    16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[7] = mk("neg_ovf",      16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vecs[8] = mk("sub_cin_ign",  16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    vecs[9] = mk("add_cin_mix",  16'hABCD, 16'h1234, 1'b0, 1'b1, 16'hBE02, 1'b0, 1'b0);

    bus16.start = 0; bus16.sub = 0; bus16.a = 0; bus16.b = 0; bus16.c_in = 0;
    bus32.start = 0; bus32.sub = 0; bus32.a = 0; bus32.b = 0; bus32.c_in = 0;
    bus8.start  = 0; bus8.sub  = 0; bus8.a  = 0; bus8.b  = 0; bus8.c_in  = 0;
    bus12.start = 0; bus12.sub = 0; bus12.a = 0; bus12.b = 0; bus12.c_in = 0;

    // Reset state.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus16.busy), 64'd0);
    check("reset done", 64'(bus16.done), 64'd0);
    check("reset sum", 64'(bus16.sum), 64'd0);
    check("reset c_out", 64'(bus16.c_out), 64'd0);
    check("reset overflow", 64'(bus16.overflow), 64'd0);
    check("reset sum w32", 64'(bus32.sum), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      run16(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].c_in, r, co, ov, lat, bc, held);
      check({vecs[i].name, " latency"}, 64'(lat), 64'd4);
      check({vecs[i].name, " busy cycles"}, 64'(bc), 64'd4);
      check({vecs[i].name, " sum held while busy"}, 64'(held), 64'd1);
      check({vecs[i].name, " sum"}, 64'(r), 64'(vecs[i].sum));
      check({vecs[i].name, " c_out"}, 64'(co), 64'(vecs[i].c_out));
      check({vecs[i].name, " overflow"}, 64'(ov), 64'(vecs[i].ovf));
      @(posedge clk); #1;
      check({vecs[i].name, " done single pulse"}, 64'(bus16.done), 64'd0);
    end

    // Back-to-back with start held high.
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.sub = 1'b0; bus16.c_in = 1'b0; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.a = 16'h5000; bus16.b = 16'h0001; bus16.sub = 1'b1;
    dcnt = 0; d1 = -1; d2 = -1; s1 = '0; s2 = '0; co2 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 5) bus16.start = 1'b0;
      if (bus16.done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = k; s1 = bus16.sum; end
        if (dcnt == 2) begin d2 = k; s2 = bus16.sum; co2 = bus16.c_out; end
      end
    end
    check("b2b done count", 64'(dcnt), 64'd2);
    check("b2b first done edge", 64'(d1), 64'd4);
    check("b2b second done edge", 64'(d2), 64'd9);
    check("b2b first sum", 64'(s1), 64'h3333);
    check("b2b second sum", 64'(s2), 64'h4FFF);
    check("b2b second c_out", 64'(co2), 64'd1);

    // Start pulsed while busy is ignored.
    bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.sub = 1'b0; bus16.c_in = 1'b0; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(posedge clk); #1;
    bus16.start = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'h0F0F; bus16.sub = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    dcnt = 0; d1 = -1; s1 = '0;
    for (int k = 3; k <= 14; k++) begin
      @(posedge clk); #1;
      if (bus16.done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = k; s1 = bus16.sum; end
      end
    end
    check("busy_protect done count", 64'(dcnt), 64'd1);
    check("busy_protect done edge", 64'(d1), 64'd4);
    check("busy_protect sum", 64'(s1), 64'h2345);

    // Leave non-zero results, then abort an operation with reset.
    run16(16'h8000, 16'h0001, 1'b1, 1'b0, r, co, ov, lat, bc, held);
    check("pre_abort sum", 64'(r), 64'h7FFF);
    @(posedge clk); #1;
    bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.sub = 1'b0; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", 64'(bus16.busy), 64'd0);
    check("abort done", 64'(bus16.done), 64'd0);
    check("abort sum", 64'(bus16.sum), 64'd0);
    check("abort c_out", 64'(bus16.c_out), 64'd0);
    check("abort overflow", 64'(bus16.overflow), 64'd0);
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus16.done || bus16.busy) dcnt++;
    end
    check("abort no activity after reset", 64'(dcnt), 64'd0);
    run16(16'h0FFF, 16'h0001, 1'b0, 1'b1, r, co, ov, lat, bc, held);
    check("post_abort latency", 64'(lat), 64'd4);
    check("post_abort sum", 64'(r), 64'h1001);
    check("post_abort c_out", 64'(co), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Parameter sweep across all instances.
    sweep_once(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    sweep_once(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    sweep_once(32'h80808080, 32'h80808080, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      sweep_once($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/chunked_add_sub.md
# chunked_add_sub

- Parametrised multi-cycle adder/subtractor; successor to the fixed 16-bit ripple adder built from 4-bit slices.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, from LSB to MSB, with a registered carry between chunks.
- Uses a start/busy/done handshake.
- Sits in the datapath wherever a wide add is needed and a single-cycle WIDTH-bit ripple chain would not meet timing.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; CHUNK = WIDTH gives single-chunk operation.

Ports:
- clk  input  1  single clock; everything is sampled on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only in IDLE or DONE.
- sub  input  1  0 = a + b + c_in; 1 = a − b (two's complement), c_in ignored.
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- c_in  input  1  carry-in for add mode, sampled on the accepting edge.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result; registered, updated only on completion.
- c_out  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
- overflow  output  1  signed overflow of the completed operation.

## Operation
- N = WIDTH/CHUNK chunks.
- Internal registers: A_r, B_r (already inverted when sub = 1), carry_r, idx (ceil(log2 N) bits, minimum 1), acc (WIDTH).
- States: IDLE, BUSY, DONE.

IDLE / DONE, start = 1:
- Latch A_r = a and B_r = sub ? ~b : b.
- carry_r = sub ? 1 : c_in; idx = 0; go to BUSY.

IDLE, start = 0:
- Stay in IDLE.

DONE, start = 0:
- Go to IDLE.

BUSY, every edge:
- {carry, chunk} = A_r[idx] + B_r[idx] + carry_r (CHUNK+1-bit add).
- Write acc[idx] = chunk; carry_r = carry; idx = idx + 1.
- On the edge processing idx = N−1:
  - Load sum from acc with the final chunk merged in.
  - Load c_out = final carry.
  - Load overflow = (A_r[MSB] == B_r[MSB]) && (result[MSB] != A_r[MSB]).
  - Go to DONE.
- start is ignored in BUSY; the operation in flight is not disturbed.

Outputs and hold behaviour:
- busy = (state == BUSY); done = (state == DONE).
- sum, c_out and overflow hold their value until the next completion; they do not change during BUSY.
- Arithmetic is modulo 2^WIDTH. c_out and overflow are independent: unsigned vs signed interpretation.

Reset (synchronous, dominates start):
- State IDLE; idx, carry_r, acc, sum, c_out, overflow, busy and done all 0.
- Reset asserted mid-BUSY aborts the operation; no done pulse follows.

## Timing
- Edge 0: start accepted.
- Edges 1..N: chunks 0..N−1 processed; busy = 1 after edges 0..N−1.
- After edge N: done = 1 and the result is on sum/c_out/overflow.
- Total: N+1 edges from accept to done.
- done lasts exactly one cycle unless start is high in that cycle. In that case the new operation is accepted on the next edge (back-to-back), giving a throughput of one result per N+1 cycles.
- CHUNK = WIDTH: N = 1, so done is visible after the 2nd edge from accept.
- Operand inputs may change freely after the accepting edge.

## Test plan
WIDTH = 16, CHUNK = 4 unless noted.
- Reset: hold reset 2 cycles → busy = done = 0, sum = 0x0000, c_out = 0, overflow = 0.
- Carry wrap: a = 0xFFFF, b = 0x0001, c_in = 0, add → after 5 edges done = 1, sum = 0x0000, c_out = 1, overflow = 0; busy high for exactly 4 cycles.
- Signed overflow: a = 0x7FFF, b = 0x0001 add → sum = 0x8000, c_out = 0, overflow = 1. Subtract: a = 0x0005, b = 0x0007 → sum = 0xFFFE, c_out = 0, overflow = 0.
- Busy protection: start with a = 0x1234, b = 0x1111; pulse start with different operands at edge 2 → result 0x2345; no extra done pulse.
- Reset mid-op: reset at edge 2 of an operation → IDLE next cycle, no done, outputs 0. A following start yields a correct result.
- Back-to-back and parameter sweep: start held high → done every 5 cycles, with correct results for two different operand pairs. Random compare against a + b + c_in for (WIDTH, CHUNK) = (16,4), (32,8), (8,8), (12,3).
